// File: rtl/instruction_fetch_unit.sv
// Fetch initiator for InstructionMem: owns the PC, issues one-deep pipelined reads,
// buffers responses and hands {pc, instr} to decode over valid/ready.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          PC_STEP   = 4,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        readadd,
   output logic [31:0] address,
   input  logic [31:0] instruction,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        halt,
   output logic        halted
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {RUN, HALT} state_t;

   state_t             state;
   state_t             nextState;
   logic [31:0]        pc;
   logic [31:0]        bufInstr [BUF_DEPTH];
   logic [31:0]        bufPc    [BUF_DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count;
   logic [CNT_W:0]     occupancy;
   logic [31:0]        target;
   logic               pop;
   logic               push;
   logic               issue;

   // readadd doubles as the in-flight flag; a redirect squashes the response it tracks
   assign pop       = if_valid & if_ready;
   assign push      = readadd & ~branch_taken;
   assign target    = branch_target & 32'hFFFF_FFFC;
   assign occupancy = {1'b0, count} - (CNT_W+1)'(pop) + (CNT_W+1)'(readadd);

   assign if_valid  = (count != '0);
   assign if_instr  = if_valid ? bufInstr[head] : 32'h0;
   assign if_pc     = if_valid ? bufPc[head]    : 32'h0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   // HALT is only entered once the last request has landed, so no response is orphaned
   always_comb begin
      nextState = state;
      if (branch_taken) begin
         nextState = RUN;
      end else begin
         case (state)
            RUN:     if (halt && !readadd) nextState = HALT;
            HALT:    if (!halt)            nextState = RUN;
            default: nextState = RUN;
         endcase
      end
   end

   always_comb begin
      halted = (state == HALT);
      issue  = (state == RUN) && !halt && (occupancy < (CNT_W+1)'(BUF_DEPTH));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= RESET_PC;
         readadd <= 1'b0;
         address <= 32'h0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
      end else if (branch_taken) begin
         readadd <= 1'b1;
         address <= target;
         pc      <= target + 32'(PC_STEP);
         head    <= '0;
         tail    <= '0;
         count   <= '0;
      end else begin
         readadd <= issue;
         if (issue) begin
            address <= pc;
            pc      <= pc + 32'(PC_STEP);
         end
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage needs no reset: if_valid gates everything read out of it
   always_ff @(posedge clk) begin
      if (reset && push) begin
         bufInstr[tail] <= instruction;
         bufPc[tail]    <= address;
      end
   end

endmodule
